// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register address / data word types and the hard-wired zero register.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package cpu_pkg;
    localparam int DATA_W     = `WORD_LEN;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/defines.sv
// Global build defines shared by the CPU datapath.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// File: rtl/wb_data_select.sv
// Write-back source priority mux: MEM over ALU over aux data.
// Latency: combinational. Backpressure: none, pure datapath.
module wb_data_select #(
    parameter int DATA_W = 32
) (
    input  logic              sel_mem,
    input  logic              sel_alu,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] aux_data,
    output logic [DATA_W-1:0] wb_data
);
    always_comb begin
        if (sel_mem)
            wb_data = mem_data;
        else if (sel_alu)
            wb_data = alu_data;
        else
            wb_data = aux_data;
    end
endmodule

// File: rtl/wb_register_file.sv
// GPR file with busy scoreboard and saturating retired-write counter; RF_BYPASS_EN forwards commits to reads.
// Latency: write visible the cycle after the commit edge (same cycle with RF_BYPASS_EN); reads combinational.
// Backpressure: none accepted; rd_busy is the stall request back to ID.
module wb_register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_write_en,
    input  logic                  wb_sel_mem,
    input  logic                  wb_sel_alu,
    input  logic [DATA_W-1:0]     wb_mem_data,
    input  logic [DATA_W-1:0]     wb_alu_data,
    input  logic [DATA_W-1:0]     wb_aux_data,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  rsv_en,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0]     rd_data1,
    output logic [DATA_W-1:0]     rd_data2,
    output logic                  rd_busy,
    output logic [CNT_W-1:0]      wr_count
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] R0 = REG_ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [DATA_W-1:0] wb_word;
    logic              commit;
    logic              reserve;

    wb_data_select #(.DATA_W(DATA_W)) u_sel (
        .sel_mem  (wb_sel_mem),
        .sel_alu  (wb_sel_alu),
        .mem_data (wb_mem_data),
        .alu_data (wb_alu_data),
        .aux_data (wb_aux_data),
        .wb_data  (wb_word)
    );

    assign commit  = wb_write_en && (wb_dst != R0);
    assign reserve = rsv_en && (rsv_addr != R0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[wb_dst] <= wb_word;
        end
    end

    // Reservation is applied after the commit clear so the younger instruction keeps ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (reserve && rsv_addr == REG_ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (commit && wb_dst == REG_ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_count <= '0;
        else if (commit && wr_count != {CNT_W{1'b1}})
            wr_count <= wr_count + CNT_W'(1);
    end

    logic hit1, hit2, busy1, busy2;

`ifdef RF_BYPASS_EN
    assign hit1 = commit && (rd_addr1 == wb_dst);
    assign hit2 = commit && (rd_addr2 == wb_dst);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rd_data1 = '0;
        busy1    = 1'b0;
        if (rd_addr1 != R0) begin
            rd_data1 = hit1 ? wb_word : regs[rd_addr1];
            busy1    = busy[rd_addr1] && !hit1;
        end
    end

    always_comb begin
        rd_data2 = '0;
        busy2    = 1'b0;
        if (rd_addr2 != R0) begin
            rd_data2 = hit2 ? wb_word : regs[rd_addr2];
            busy2    = busy[rd_addr2] && !hit2;
        end
    end

    assign rd_busy = busy1 | busy2;
endmodule

// File: tb/tb_wb_register_file.sv
// Randomized self-checking bench for wb_register_file against a behavioural register-file model.
module tb_wb_register_file;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_write_en = 0, wb_sel_mem = 0, wb_sel_alu = 0;
    logic [31:0] wb_mem_data = 0, wb_alu_data = 0, wb_aux_data = 0;
    logic [4:0]  wb_dst = 0, rsv_addr = 0, rd_addr1 = 0, rd_addr2 = 0;
    logic        rsv_en = 0;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    wb_register_file dut (
        .clk(clk), .rst(rst),
        .wb_write_en(wb_write_en), .wb_sel_mem(wb_sel_mem), .wb_sel_alu(wb_sel_alu),
        .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data), .wb_aux_data(wb_aux_data),
        .wb_dst(wb_dst), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_busy(rd_busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          m_cnt;

    function automatic logic [31:0] sel_word();
        if (wb_sel_mem) return wb_mem_data;
        if (wb_sel_alu) return wb_alu_data;
        return wb_aux_data;
    endfunction

    function automatic bit fwd(input logic [4:0] a);
        return BYP && wb_write_en && wb_dst != 0 && a == wb_dst;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (fwd(a)) return sel_word();
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        return a != 0 && m_busy[a] && !fwd(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 0;
            end
            m_cnt = 0;
        end else begin
            if (wb_write_en && wb_dst != 0) begin
                m_regs[wb_dst] = sel_word();
                m_busy[wb_dst] = 0;
                if (m_cnt < 65535) m_cnt++;
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        #2;
        if (cmp_en && !rst) begin
            chk("rd_data1", rd_data1, exp_data(rd_addr1));
            chk("rd_data2", rd_data2, exp_data(rd_addr2));
            chk("rd_busy", {31'b0, rd_busy}, {31'b0, exp_busy(rd_addr1) | exp_busy(rd_addr2)});
            chk("wr_count", {16'b0, wr_count}, m_cnt);
        end
    end

    task automatic drive(input bit we, input bit sm, input bit sa, input logic [31:0] md,
                         input logic [31:0] ad, input logic [31:0] xd, input logic [4:0] dst,
                         input bit re, input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2);
        wb_write_en = we; wb_sel_mem = sm; wb_sel_alu = sa;
        wb_mem_data = md; wb_alu_data = ad; wb_aux_data = xd; wb_dst = dst;
        rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;

        // 1. reset state
        for (int a = 0; a < 32; a += 2) begin
            idle(5'(a), 5'(a + 1));
            #3;
            chk("reset_rd1", rd_data1, 32'h0);
            chk("reset_rd2", rd_data2, 32'h0);
            chk("reset_busy", {31'b0, rd_busy}, 32'h0);
            @(negedge clk);
        end
        chk("reset_cnt", {16'b0, wr_count}, 32'h0);

        // 2. ALU commit, then MEM wins over ALU
        drive(1, 0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 5'd5, 0, 0, 5'd5, 5'd0);
        @(negedge clk); idle(5'd5, 5'd0); #3;
        chk("r5_alu", rd_data1, 32'hDEADBEEF);
        chk("cnt1", {16'b0, wr_count}, 32'd1);
        @(negedge clk);
        drive(1, 1, 1, 32'h11, 32'h22, 32'h33, 5'd5, 0, 0, 5'd0, 5'd0);
        @(negedge clk); idle(5'd0, 5'd5); #3;
        chk("r5_mem", rd_data2, 32'h11);
        chk("cnt2", {16'b0, wr_count}, 32'd2);
        @(negedge clk);

        // 3. R0 write ignored
        drive(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 5'd0, 0, 0, 5'd0, 5'd0);
        @(negedge clk); idle(5'd0, 5'd0); #3;
        chk("r0_zero", rd_data1, 32'h0);
        chk("r0_cnt", {16'b0, wr_count}, 32'd2);
        @(negedge clk);

        // 4. reservation and commit to R7
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        @(negedge clk); idle(5'd7, 5'd0); #3;
        chk("r7_busy", {31'b0, rd_busy}, 32'd1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'hA5A5_0007, 5'd7, 0, 0, 5'd7, 5'd0);
        #3;
        chk("r7_commit_busy", {31'b0, rd_busy}, BYP ? 32'd0 : 32'd1);
        chk("r7_commit_data", rd_data1, BYP ? 32'hA5A5_0007 : 32'h0);
        @(negedge clk); idle(5'd7, 5'd0); #3;
        chk("r7_after_busy", {31'b0, rd_busy}, 32'd0);
        chk("r7_after_data", rd_data1, 32'hA5A5_0007);
        @(negedge clk);

        // 5. same-cycle reserve + commit of R9 keeps it busy; then async reset mid-cycle
        drive(1, 0, 1, 0, 32'h99, 0, 5'd9, 1, 5'd9, 5'd0, 5'd0);
        @(negedge clk); idle(5'd9, 5'd5); #3;
        chk("r9_busy", {31'b0, rd_busy}, 32'd1);
        chk("r9_data", rd_data1, 32'h99);
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, rd_busy}, 32'd0);
        chk("rst_r9", rd_data1, 32'h0);
        chk("rst_r5", rd_data2, 32'h0);
        chk("rst_cnt", {16'b0, wr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 3) == 0, 5'($urandom),
                  5'($urandom), ($urandom_range(0, 3) == 0) ? wb_dst : 5'($urandom));
            @(negedge clk);
        end

        // 6. saturation: reset, run to 0xFFFE, then three more commits
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 16'hFFFE; n++) begin
            drive(1, 0, 1, 0, n, 0, 5'(1 + (n % 31)), 0, 0, 5'(1 + (n % 31)), 5'd3);
            @(negedge clk);
        end
        idle(5'd0, 5'd0); #3;
        chk("cnt_fffe", {16'b0, wr_count}, 32'hFFFE);
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            drive(1, 0, 0, 0, 0, 32'hC0DE_0000 + n, 5'd12, 0, 0, 5'd12, 5'd0);
            @(negedge clk);
        end
        idle(5'd12, 5'd0); #3;
        chk("cnt_sat", {16'b0, wr_count}, 32'hFFFF);
        chk("sat_data", rd_data1, 32'hC0DE_0002);
        @(negedge clk);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
